lsu_clkgate_ctrl: RTL and testbench
===================================

Name: lsu_clkgate_ctrl

Overview:
Parametrised clock-enable and clock-gating controller for the LSU pipeline. It generalises per-stage c1/c2 enable generation to NUM_STAGES stages, adds freeze-qualified enables, and gives each of NUM_BUF buffer clock domains an IDLE/ACTIVE/DRAIN state machine with a programmable hold-off so each buffer clock stays on for hold_cfg cycles after activity ends. It sits beside the LSU datapath and drives rvoclkhdr instances, one per gated clock.

Parameters:
NUM_STAGES, 5, pipeline stages dc1..dcN; legal range 2..8.
NUM_BUF, 3, independent buffer clock domains (stbuf, ibuf, obuf, ...); legal range 1..8.
HOLD_W, 4, width of the hold-off counter and of hold_cfg.

Ports:
clk  in  1  core clock (free-running).
rst_l  in  1  asynchronous active-low reset.
scan_mode  in  1  forces all gated clocks on through the clock headers.
clk_override  in  1  debug control bit; forces every enable to 1.
freeze  in  1  pipeline freeze; masks freeze_c1_clken.
pkt_valid  in  NUM_STAGES+1  bit 0 = decode packet valid; bit i = dc(i) packet valid.
dma_req  in  1  DMA request active.
buf_busy  in  NUM_BUF  per-buffer activity request.
hold_cfg  in  HOLD_W  hold-off length in cycles; sampled when a channel enters DRAIN.
stage_c1_clken  out  NUM_STAGES  single-pulse enable per stage.
stage_c2_clken  out  NUM_STAGES  double-pulse enable per stage.
freeze_c1_clken  out  NUM_STAGES  freeze-qualified enable per stage.
stage_c1_clk  out  NUM_STAGES  gated clock per stage, from c1 enable.
stage_c2_clk  out  NUM_STAGES  gated clock per stage, from c2 enable.
buf_clken  out  NUM_BUF  buffer clock enable.
buf_clk  out  NUM_BUF  gated buffer clock.
free_clken  out  1  LSU-global activity enable.
idle  out  1  whole LSU quiescent.
gated_cycles  out  32  clock-gating statistics (see Optional Feature).

Behaviour:
- All flops are clocked by clk and cleared asynchronously when rst_l=0: c1_q[*], free_q, each channel state = IDLE, each counter = 0, gated_cycles = 0.
- All outputs are combinational from inputs and these flops. With every input at 0, during and after reset, all enables are 0, idle = 1 and gated_cycles = 0.
- stage_c1_clken[0] = pkt_valid[0] | dma_req | clk_override.
- stage_c1_clken[i] = pkt_valid[i] | c1_q[i-1] | clk_override, for i ≥ 1.
- c1_q[i] <= stage_c1_clken[i]. Enables therefore propagate one stage per cycle and are not blocked by freeze.
- stage_c2_clken[i] = stage_c1_clken[i] | c1_q[i] | clk_override, giving a two-cycle window.
- freeze_c1_clken[i] = (pkt_valid[i] | (i==0 & dma_req) | clk_override) & ~freeze.
- Buffer FSM, one per channel:
  - IDLE: buf_busy=1 → ACTIVE.
  - ACTIVE: buf_busy=0 → DRAIN with cnt <= hold_cfg; if hold_cfg==0 → IDLE directly.
  - DRAIN: buf_busy=1 → ACTIVE; this takes priority over the count. Otherwise cnt decrements; the transition to IDLE happens in the cycle where cnt==1.
- buf_clken[b] = (state≠IDLE) | buf_busy[b] | clk_override. The enable asserts combinationally in the cycle buf_busy rises and deasserts exactly hold_cfg cycles after buf_busy falls.
- Changes to hold_cfg during DRAIN do not affect the count already loaded.
- free_c1 = |pkt_valid | |buf_busy | clk_override; free_q <= free_c1; free_clken = free_c1 | free_q.
- idle = ~free_clken & all channels in IDLE & ~|c1_q.
- Gated clocks: one rvoclkhdr per output bit, with .en = the matching enable and scan_mode passed through.
- Reset mid-operation: all FSMs go to IDLE immediately and any hold-off in progress is abandoned.

Optional Feature:
LSU_CLKGATE_STATS_EN:
- Defined: gated_cycles increments every clk cycle in which free_clken==0. It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Not defined: gated_cycles is tied to 0 and no counter logic is built. The port exists in both builds.

Test Plan:
1. Reset, all inputs 0 → all enables 0, idle=1, gated_cycles=0.
2. NUM_STAGES=5, single-cycle pkt_valid[0] at cycle 0 → stage_c1_clken[k] high only in cycle k (k=0..4); stage_c2_clken[k] high in cycles k and k+1; idle=0 through cycle 5.
3. freeze=1 with pkt_valid[2]=1 → freeze_c1_clken[2]=0 while stage_c1_clken[2]=1.
4. hold_cfg=3, buf_busy[1] high for cycles 0–4 → buf_clken[1] high cycles 0–7 and low at cycle 8; hold_cfg=0 → low at cycle 5.
5. buf_busy re-asserted with 1 cycle left in DRAIN → FSM returns to ACTIVE and the enable stays high with no gap; rst_l pulsed mid-DRAIN → buf_clken drops in the same cycle.
6. STATS_EN build, 10 fully idle cycles after reset → gated_cycles=10; clk_override=1 → counter frozen.

Source files
------------

// File: rtl/lsu_clkgate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_clkgate_ctrl_if
// Description : Bundles the activity inputs, the enable outputs and the gated
//               clock outputs of the LSU clock-gating controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_clkgate_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_BUF    = 3,
    parameter int HOLD_W     = 4
);
    // activity / control inputs to the controller
    logic                  scan_mode;
    logic                  clk_override;
    logic                  freeze;
    logic [NUM_STAGES:0]   pkt_valid;
    logic                  dma_req;
    logic [NUM_BUF-1:0]    buf_busy;
    logic [HOLD_W-1:0]     hold_cfg;

    // enables, gated clocks and status from the controller
    logic [NUM_STAGES-1:0] stage_c1_clken;
    logic [NUM_STAGES-1:0] stage_c2_clken;
    logic [NUM_STAGES-1:0] freeze_c1_clken;
    logic [NUM_STAGES-1:0] stage_c1_clk;
    logic [NUM_STAGES-1:0] stage_c2_clk;
    logic [NUM_BUF-1:0]    buf_clken;
    logic [NUM_BUF-1:0]    buf_clk;
    logic                  free_clken;
    logic                  idle;
    logic [31:0]           gated_cycles;

    // side that produces activity and consumes enables
    modport master (
        output scan_mode, clk_override, freeze, pkt_valid, dma_req,
               buf_busy, hold_cfg,
        input  stage_c1_clken, stage_c2_clken, freeze_c1_clken,
               stage_c1_clk, stage_c2_clk, buf_clken, buf_clk,
               free_clken, idle, gated_cycles
    );

    // controller side
    modport slave (
        input  scan_mode, clk_override, freeze, pkt_valid, dma_req,
               buf_busy, hold_cfg,
        output stage_c1_clken, stage_c2_clken, freeze_c1_clken,
               stage_c1_clk, stage_c2_clk, buf_clken, buf_clk,
               free_clken, idle, gated_cycles
    );
endinterface
`default_nettype wire

// File: rtl/lsu_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_clkgate_ctrl (with clock header rvoclkhdr)
// Description : Per-stage c1/c2/freeze-qualified clock enables for an
//               NUM_STAGES-deep LSU pipeline, plus NUM_BUF buffer clock
//               domains each held on for hold_cfg cycles after activity ends.
//               Optional gated-cycle statistics counter: LSU_CLKGATE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================

// Glitch-free clock header: enable is captured while clk is low.
module rvoclkhdr (
    input  wire logic en,
    input  wire logic clk,
    input  wire logic scan_mode,
    output logic      l1clk
);
    logic r_en_lat;

    // capture enable on the falling edge so l1clk cannot glitch in the high phase
    always_ff @(negedge clk) begin
        r_en_lat <= en | scan_mode;
    end

    assign l1clk = clk & r_en_lat;
endmodule

module lsu_clkgate_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_BUF    = 3,
    parameter int HOLD_W     = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_l,
    lsu_clkgate_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } buf_state_t;

    localparam logic [HOLD_W-1:0] C_CNT_ONE = HOLD_W'(1);

    logic [NUM_STAGES-1:0] r_c1_q;
    logic [NUM_STAGES-1:0] w_c1_clken;
    logic [NUM_STAGES-1:0] w_c2_clken;
    logic [NUM_STAGES-1:0] w_frz_clken;
    logic [NUM_STAGES-1:0] w_c1_clk;
    logic [NUM_STAGES-1:0] w_c2_clk;
    logic [NUM_BUF-1:0]    w_buf_clken;
    logic [NUM_BUF-1:0]    w_buf_clk;
    logic [NUM_BUF-1:0]    w_chan_idle;
    logic                  w_free_c1;
    logic                  r_free_q;
    logic                  w_free_clken;

    // ------------------------------------------------------------------
    // Pipeline stage enables
    // ------------------------------------------------------------------
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            // decode stage is woken by a decode packet or a DMA request
            assign w_c1_clken[s]  = bus.pkt_valid[s] | bus.dma_req | bus.clk_override;
            assign w_frz_clken[s] = (bus.pkt_valid[s] | bus.dma_req | bus.clk_override)
                                    & ~bus.freeze;
        end else begin : g_rest
            // later stages follow the previous stage's enable one cycle behind
            assign w_c1_clken[s]  = bus.pkt_valid[s] | r_c1_q[s-1] | bus.clk_override;
            assign w_frz_clken[s] = (bus.pkt_valid[s] | bus.clk_override) & ~bus.freeze;
        end
        // c2 stays on for the cycle after c1 as well
        assign w_c2_clken[s] = w_c1_clken[s] | r_c1_q[s] | bus.clk_override;

        rvoclkhdr u_c1_hdr (
            .en        (w_c1_clken[s]),
            .clk       (clk),
            .scan_mode (bus.scan_mode),
            .l1clk     (w_c1_clk[s])
        );
        rvoclkhdr u_c2_hdr (
            .en        (w_c2_clken[s]),
            .clk       (clk),
            .scan_mode (bus.scan_mode),
            .l1clk     (w_c2_clk[s])
        );
    end

    // stage enable history; freeze does not stop propagation
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_c1_q <= '0;
        end else begin
            r_c1_q <= w_c1_clken;
        end
    end

    // ------------------------------------------------------------------
    // Buffer clock domains
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
        buf_state_t        r_state;
        buf_state_t        w_state_nxt;
        logic [HOLD_W-1:0] r_cnt;
        logic [HOLD_W-1:0] w_cnt_nxt;

        // channel state and hold-off counter
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // next-state: busy always wins; DRAIN counts down a latched hold_cfg
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.buf_busy[b]) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!bus.buf_busy[b]) begin
                        if (bus.hold_cfg == '0) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                            w_cnt_nxt   = bus.hold_cfg;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.buf_busy[b]) begin
                        w_state_nxt = ST_ACTIVE;
                    end else if (r_cnt <= C_CNT_ONE) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - C_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // The enable looks at where the channel is going: it rises with busy
        // and drops in the cycle the last hold-off edge is no longer needed,
        // so the domain sees exactly hold_cfg extra cycles after busy falls.
        assign w_buf_clken[b] = (w_state_nxt != ST_IDLE) | bus.buf_busy[b] | bus.clk_override;
        assign w_chan_idle[b] = (r_state == ST_IDLE);

        rvoclkhdr u_buf_hdr (
            .en        (w_buf_clken[b]),
            .clk       (clk),
            .scan_mode (bus.scan_mode),
            .l1clk     (w_buf_clk[b])
        );
    end

    // ------------------------------------------------------------------
    // Global activity and idle
    // ------------------------------------------------------------------
    assign w_free_c1    = (|bus.pkt_valid) | (|bus.buf_busy) | bus.clk_override;
    assign w_free_clken = w_free_c1 | r_free_q;

    // one-cycle extension of the global activity enable
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_free_q <= 1'b0;
        end else begin
            r_free_q <= w_free_c1;
        end
    end

`ifdef LSU_CLKGATE_STATS_EN
    logic [31:0] r_gated_cycles;

    // count cycles with the global enable off, saturating
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_gated_cycles <= 32'd0;
        end else if (!w_free_clken && (r_gated_cycles != 32'hFFFF_FFFF)) begin
            r_gated_cycles <= r_gated_cycles + 32'd1;
        end
    end

    assign bus.gated_cycles = r_gated_cycles;
`else
    assign bus.gated_cycles = 32'd0;
`endif

    assign bus.stage_c1_clken  = w_c1_clken;
    assign bus.stage_c2_clken  = w_c2_clken;
    assign bus.freeze_c1_clken = w_frz_clken;
    assign bus.stage_c1_clk    = w_c1_clk;
    assign bus.stage_c2_clk    = w_c2_clk;
    assign bus.buf_clken       = w_buf_clken;
    assign bus.buf_clk         = w_buf_clk;
    assign bus.free_clken      = w_free_clken;
    assign bus.idle            = ~w_free_clken & (&w_chan_idle) & ~(|r_c1_q);
endmodule
`default_nettype wire

// File: tb/tb_lsu_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_clkgate_ctrl
// Description : Directed self-checking bench for lsu_clkgate_ctrl
//               (NUM_STAGES=5, NUM_BUF=3, HOLD_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_clkgate_ctrl;
    localparam int NS = 5;
    localparam int NB = 3;
    localparam int HW = 4;

    logic clk;
    logic rst_l;
    int   total;
    int   bad;

    lsu_clkgate_ctrl_if #(.NUM_STAGES(NS), .NUM_BUF(NB), .HOLD_W(HW)) bus ();

    lsu_clkgate_ctrl #(.NUM_STAGES(NS), .NUM_BUF(NB), .HOLD_W(HW)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.scan_mode    = 1'b0;
        bus.clk_override = 1'b0;
        bus.freeze       = 1'b0;
        bus.pkt_valid    = '0;
        bus.dma_req      = 1'b0;
        bus.buf_busy     = '0;
        bus.hold_cfg     = '0;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
    endtask

    logic [4:0] exp_c1   [7] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00};
    logic [4:0] exp_c2   [7] = '{5'h01, 5'h03, 5'h06, 5'h0C, 5'h18, 5'h10, 5'h00};
    logic       exp_idle [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_free [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_gated;

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst_l = 1'b0;

        // reset state, all inputs 0
        tick();
        @(negedge clk);
        check("rst_c1", 32'(bus.stage_c1_clken), 32'h0);
        check("rst_c2", 32'(bus.stage_c2_clken), 32'h0);
        check("rst_frz", 32'(bus.freeze_c1_clken), 32'h0);
        check("rst_buf", 32'(bus.buf_clken), 32'h0);
        check("rst_free", 32'(bus.free_clken), 32'h0);
        check("rst_idle", 32'(bus.idle), 32'h1);
        check("rst_gated", bus.gated_cycles, 32'h0);
        tick();
        rst_l = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(bus.idle), 32'h1);
        check("post_rst_c2", 32'(bus.stage_c2_clken), 32'h0);

        // single-cycle decode packet ripples down the pipe
        tick();
        bus.pkt_valid = 6'b000001;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("ripple_c1_%0d", k), 32'(bus.stage_c1_clken), 32'(exp_c1[k]));
            check($sformatf("ripple_c2_%0d", k), 32'(bus.stage_c2_clken), 32'(exp_c2[k]));
            check($sformatf("ripple_idle_%0d", k), 32'(bus.idle), 32'(exp_idle[k]));
            check($sformatf("ripple_free_%0d", k), 32'(bus.free_clken), 32'(exp_free[k]));
            tick();
            bus.pkt_valid = '0;
        end

        // DMA request wakes stage 0 only
        bus.dma_req = 1'b1;
        @(negedge clk);
        check("dma_c1", 32'(bus.stage_c1_clken), 32'h01);
        check("dma_frz", 32'(bus.freeze_c1_clken), 32'h01);
        tick();
        bus.dma_req = 1'b0;
        repeat (7) tick();

        // freeze masks only the freeze-qualified enable
        bus.freeze    = 1'b1;
        bus.pkt_valid = 6'b000100;
        @(negedge clk);
        check("frz_c1", 32'(bus.stage_c1_clken), 32'h04);
        check("frz_frz", 32'(bus.freeze_c1_clken), 32'h00);
        tick();
        bus.freeze = 1'b0;
        @(negedge clk);
        check("unfrz_c1", 32'(bus.stage_c1_clken), 32'h0C);
        check("unfrz_frz", 32'(bus.freeze_c1_clken), 32'h04);
        tick();
        bus.freeze       = 1'b1;
        bus.clk_override = 1'b1;
        @(negedge clk);
        check("ovr_c1", 32'(bus.stage_c1_clken), 32'h1F);
        check("ovr_c2", 32'(bus.stage_c2_clken), 32'h1F);
        check("ovr_frz", 32'(bus.freeze_c1_clken), 32'h00);
        check("ovr_buf", 32'(bus.buf_clken), 32'h7);
        tick();
        clear_inputs();
        repeat (8) tick();

        // hold_cfg=3, busy[1] cycles 0..4: enable cycles 0..7
        bus.hold_cfg = 4'd3;
        for (int k = 0; k < 10; k++) begin
            bus.buf_busy = (k <= 4) ? 3'b010 : 3'b000;
            @(negedge clk);
            check($sformatf("hold3_%0d", k), 32'(bus.buf_clken), (k <= 7) ? 32'h2 : 32'h0);
            tick();
        end

        // hold_cfg=0: enable drops the cycle busy falls
        bus.hold_cfg = 4'd0;
        for (int k = 0; k < 7; k++) begin
            bus.buf_busy = (k <= 4) ? 3'b010 : 3'b000;
            @(negedge clk);
            check($sformatf("hold0_%0d", k), 32'(bus.buf_clken), (k <= 4) ? 32'h2 : 32'h0);
            tick();
        end

        // busy returns in the last DRAIN cycle; later hold_cfg change is ignored
        for (int k = 0; k < 14; k++) begin
            bus.buf_busy = (k <= 4 || k == 7 || k == 8) ? 3'b010 : 3'b000;
            bus.hold_cfg = (k >= 10) ? 4'd0 : 4'd3;
            @(negedge clk);
            check($sformatf("rearm_%0d", k), 32'(bus.buf_clken), (k <= 11) ? 32'h2 : 32'h0);
            tick();
        end

        // reset pulse mid-DRAIN drops the enable at once
        bus.hold_cfg = 4'd3;
        bus.buf_busy = 3'b001;
        tick();
        bus.buf_busy = 3'b000;
        tick();
        tick();
        #1;
        check("drain_before_rst", 32'(bus.buf_clken), 32'h1);
        rst_l = 1'b0;
        #1;
        check("drain_in_rst", 32'(bus.buf_clken), 32'h0);
        check("drain_rst_idle", 32'(bus.idle), 32'h1);
        #1;
        rst_l = 1'b1;
        @(negedge clk);
        check("drain_after_rst", 32'(bus.buf_clken), 32'h0);
        tick();

        // gated clocks: scan_mode forces every header on
        bus.scan_mode = 1'b1;
        @(negedge clk);
        tick();
        check("scan_bufclk", 32'(bus.buf_clk), 32'h7);
        check("scan_c1clk", 32'(bus.stage_c1_clk), 32'h1F);
        bus.scan_mode = 1'b0;
        @(negedge clk);
        tick();
        check("off_bufclk", 32'(bus.buf_clk), 32'h0);
        bus.buf_busy = 3'b001;
        @(negedge clk);
        tick();
        bus.buf_busy = 3'b000;
        check("busy_bufclk", 32'(bus.buf_clk), 32'h1);
        check("busy_c2clk", 32'(bus.stage_c2_clk), 32'h0);
        clear_inputs();
        repeat (3) tick();

        // statistics: 10 idle cycles after reset, then frozen by override
`ifdef LSU_CLKGATE_STATS_EN
        exp_gated = 32'd10;
`else
        exp_gated = 32'd0;
`endif
        do_reset();
        repeat (10) tick();
        @(negedge clk);
        check("gated_10", bus.gated_cycles, exp_gated);
        bus.clk_override = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("gated_frozen", bus.gated_cycles, exp_gated);
        bus.clk_override = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
